// File: rtl/mem_arb_ctrl.sv
// Two-requester single-port RAM arbiter and access sequencer.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise requester 0 has fixed priority.
module mem_arb_ctrl #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [1:0] LAST_CNT = 2'(RD_LAT - 1);

    state_e              state_q, state_d;
    logic [1:0]          gnt_q, gnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                win;

`ifdef ARB_ROUND_ROBIN_EN
    logic                last_q, last_d;

    // On a tie the requester not served most recently wins.
    always_comb begin
        win = ~req[0];
        if (req == 2'b11) begin
            win = ~last_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        win = ~req[0];
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (req != 2'b00) begin
                    state_d = ACCESS;
                    gnt_d   = win ? 2'b10 : 2'b01;
                    we_d    = we[win];
                    addr_d  = win ? addr1 : addr0;
                    wdata_d = win ? wdata1 : wdata0;
                end
            end
            ACCESS: begin
                cnt_d   = '0;
                state_d = we_q ? DONE : WAIT;
            end
            WAIT: begin
                if (cnt_q == LAST_CNT) begin
                    rdata_d = mem_rdata;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
`ifdef ARB_ROUND_ROBIN_EN
                last_d  = gnt_q[1];
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes decode straight from state so reset drops them immediately.
    assign mem_en    = (state_q == ACCESS);
    assign mem_we    = (state_q == ACCESS) & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign gnt       = gnt_q;
    assign done      = (state_q == DONE) ? gnt_q : 2'b00;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Randomized scoreboard bench for mem_arb_ctrl against a transaction-level timing/arbitration model.
`timescale 1ns/1ps
module tb_mem_arb_ctrl;

    localparam int AW  = 4;
    localparam int DW  = 8;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req, we, gnt, done;
    logic [AW-1:0] addr0, addr1, mem_addr;
    logic [DW-1:0] wdata0, wdata1, rdata, mem_wdata, mem_rdata;
    logic          mem_en, mem_we;

    mem_arb_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt), .done(done), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: data valid LAT cycles after the mem_en cycle, junk otherwise.
    logic [DW-1:0] ram [1<<AW];
    bit            ram_ready = 1'b0;
    logic [LAT-1:0] pv = '0;
    logic [DW-1:0] pd [LAT];
    logic [DW-1:0] junk = '0;
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int k = 0; k < (1<<AW); k++) ram[k] <= DW'(k*37 + 5);
            ram_ready <= 1'b1;
        end else if (mem_en && mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        for (int k = LAT-1; k > 0; k--) begin
            pv[k] <= pv[k-1];
            pd[k] <= pd[k-1];
        end
        pv[0] <= mem_en & ~mem_we;
        pd[0] <= ram[mem_addr];
        junk  <= DW'($urandom);
    end
    assign mem_rdata = pv[LAT-1] ? pd[LAT-1] : junk;

    typedef struct { int cyc; bit w; logic [AW-1:0] a; logic [DW-1:0] d; } acc_t;
    typedef struct { int cyc; int acc; int who; bit w; logic [DW-1:0] rd; } don_t;
    acc_t acc_q[$];
    don_t don_q[$];

    int checks = 0;
    int errors = 0;
    bit in_reset = 1'b1;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT strobes, checks gnt/rdata every cycle.
    initial begin
        logic [DW-1:0] rd_hold;
        logic [1:0]    eg;
        acc_t          a;
        don_t          d;
        int            t;
        rd_hold = '0;
        forever begin
            @(negedge clk);
            t = cyc;
            if (in_reset) begin
                rd_hold = '0;
                continue;
            end
            if (mem_en) begin
                if (acc_q.size() == 0) begin
                    chk("mem_en_unexpected", mem_en, 0);
                end else begin
                    a = acc_q.pop_front();
                    chk("access_cycle", t, a.cyc);
                    chk("mem_we", mem_we, a.w);
                    chk("mem_addr", mem_addr, a.a);
                    if (a.w) chk("mem_wdata", mem_wdata, a.d);
                end
            end else begin
                chk("mem_we_idle", mem_we, 0);
                if (acc_q.size() != 0 && acc_q[0].cyc <= t) begin
                    a = acc_q.pop_front();
                    chk("mem_en_missing", mem_en, 1);
                end
            end
            eg = 2'b00;
            if (don_q.size() != 0 && t >= don_q[0].acc && t <= don_q[0].cyc)
                eg = 2'b01 << don_q[0].who;
            chk("gnt", gnt, eg);
            if (done != 2'b00) begin
                if (don_q.size() == 0) begin
                    chk("done_unexpected", done, 0);
                end else begin
                    d = don_q.pop_front();
                    chk("done_cycle", t, d.cyc);
                    chk("done_who", done, 2'b01 << d.who);
                    if (!d.w) rd_hold = d.rd;
                end
            end else if (don_q.size() != 0 && don_q[0].cyc <= t) begin
                d = don_q.pop_front();
                chk("done_missing", done, 2'b01 << d.who);
            end
            chk("rdata", rdata, rd_hold);
        end
    end

    // Requester/model state owned by the driver.
    bit            act [2];
    bit            smp [2];
    bit            wfl [2];
    int            scyc [2];
    int            dcyc [2];
    int            free_cyc, last_srv, completed, phase, pcnt;
    logic [DW-1:0] shadow [1<<AW];

    task automatic set_in(input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        we[i] = w;
        if (i == 0) begin
            addr0 = a; wdata0 = d;
        end else begin
            addr1 = a; wdata1 = d;
        end
    endtask

    task automatic start_req(input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        act[i] = 1'b1;
        smp[i] = 1'b0;
        req[i] = 1'b1;
        set_in(i, w, a, d);
    endtask

    // Transaction-level model: arbitration whenever the controller is free,
    // fixed completion latencies, shadow memory for read data.
    task automatic arbitrate(input int t);
        bit p0, p1, wb;
        int w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        acc_t ea;
        don_t ed;
        if (t < free_cyc) return;
        p0 = act[0] && !smp[0];
        p1 = act[1] && !smp[1];
        if (!p0 && !p1) return;
        if (p0 && p1) begin
`ifdef ARB_ROUND_ROBIN_EN
            w = (last_srv == 0) ? 1 : 0;
`else
            w = 0;
`endif
        end else begin
            w = p0 ? 0 : 1;
        end
        wb = we[w];
        a  = (w == 0) ? addr0 : addr1;
        d  = (w == 0) ? wdata0 : wdata1;
        smp[w]  = 1'b1;
        wfl[w]  = wb;
        scyc[w] = t;
        dcyc[w] = wb ? t + 2 : t + 2 + LAT;
        free_cyc = dcyc[w] + 1;
        last_srv = w;
        ea = '{cyc: t + 1, w: wb, a: a, d: d};
        ed = '{cyc: dcyc[w], acc: t + 1, who: w, w: wb, rd: shadow[a]};
        if (wb) shadow[a] = d;
        acc_q.push_back(ea);
        don_q.push_back(ed);
    endtask

    task automatic random_step(input int t, input int rd_bias);
        for (int i = 0; i < 2; i++) begin
            if (act[i] && smp[i] && t > scyc[i]) begin
                if ($urandom_range(0, 1) == 1)
                    set_in(i, 1'($urandom), AW'($urandom), DW'($urandom));
                if ($urandom_range(0, 3) == 0) req[i] = 1'b0;
            end else if (!act[i] && $urandom_range(0, 2) == 0) begin
                start_req(i, ($urandom_range(0, rd_bias) == 0), AW'($urandom), DW'($urandom));
            end
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_gnt"}, gnt, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_mem_en"}, mem_en, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_rdata"}, rdata, 0);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0;
            smp[i] = 1'b0;
        end
        req = 2'b00;
        acc_q.delete();
        don_q.delete();
        last_srv = 1;
    endtask

    initial begin
        int t;
        rst = 1'b1; req = 2'b00; we = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        for (int k = 0; k < (1<<AW); k++) shadow[k] = DW'(k*37 + 5);
        clear_model();
        completed = 0; phase = 0; pcnt = 0;
        repeat (2) @(posedge clk);
        #1 reset_checks("por");
        @(negedge clk);
        #1 rst = 1'b0;
        in_reset = 1'b0;
        free_cyc = cyc;
        for (int n = 0; n < 4000 && phase < 6; n++) begin
            t = cyc;
            for (int i = 0; i < 2; i++) begin
                if (act[i] && smp[i] && dcyc[i] == t) begin
                    act[i] = 1'b0;
                    req[i] = 1'b0;
                    completed++;
                end
            end
            case (phase)
                0: begin
                    if (completed == 0 && !act[0]) start_req(0, 1'b1, 4'd3, 8'hA5);
                    if (completed == 1 && !act[1]) start_req(1, 1'b0, 4'd3, 8'h00);
                    // Requester 1 drops its request while its read is in flight.
                    if (act[1] && smp[1] && t == scyc[1] + 1) req[1] = 1'b0;
                    if (completed == 2) phase = 1;
                end
                1: begin
                    for (int i = 0; i < 2; i++)
                        if (!act[i]) start_req(i, 1'b0, AW'($urandom), DW'($urandom));
                    if (completed >= 8) begin
                        phase = 2; pcnt = 0;
                    end
                end
                2: begin
                    random_step(t, 1);
                    pcnt++;
                    if (pcnt == 300) begin
                        phase = 3; pcnt = 0;
                    end
                end
                3: begin
                    if ((act[0] && smp[0] && !wfl[0] && t >= scyc[0] + 2) ||
                        (act[1] && smp[1] && !wfl[1] && t >= scyc[1] + 2)) begin
                        in_reset = 1'b1;
                        rst = 1'b1;
                        #1 reset_checks("wait_rst");
                        clear_model();
                        @(posedge clk);
                        #1 chk("rst_hold_done", done, 0);
                        chk("rst_hold_gnt", gnt, 0);
                        @(negedge clk);
                        #1 rst = 1'b0;
                        in_reset = 1'b0;
                        t = cyc;
                        free_cyc = t;
                        phase = 4; pcnt = 0;
                        start_req(1, 1'b1, AW'($urandom), DW'($urandom));
                    end else begin
                        random_step(t, 4);
                        pcnt++;
                        if (pcnt > 600) begin
                            phase = 4; pcnt = 0;
                        end
                    end
                end
                4: begin
                    random_step(t, 1);
                    pcnt++;
                    if (pcnt == 200) begin
                        phase = 5; pcnt = 0;
                    end
                end
                default: begin
                    pcnt++;
                    if ((!act[0] && !act[1] && acc_q.size() == 0 && don_q.size() == 0) || pcnt > 100)
                        phase = 6;
                end
            endcase
            arbitrate(t);
            @(negedge clk);
        end
        @(negedge clk);
        chk("pending_access", acc_q.size(), 0);
        chk("pending_done", don_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
